// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, index/data types and opcode constants.
package cpu_pkg;

    localparam int unsigned NREG = 8;
    localparam int unsigned DW   = 16;
    localparam int unsigned CNTW = 2;
    localparam int unsigned IW   = $clog2(NREG);

    typedef logic [IW-1:0] regnum_t;
    typedef logic [DW-1:0] word_t;

    localparam logic [2:0] LDR = 3'b011;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback <-> register file bundle. The master is the pipeline side
// (decode and the final stage); the slave is the register file and scoreboard.
interface regfile_scoreboard_if;
    import cpu_pkg::*;

    logic             flush_in;
    logic             issue_in;
    logic             issue_write_in;
    regnum_t          issue_writenum_in;
    logic             use_a_in;
    logic             use_b_in;
    regnum_t          readnum_a_in;
    regnum_t          readnum_b_in;
    logic             write_in;
    regnum_t          writenum_in;
    word_t            writeback_data_in;
    word_t            data_a_out;
    word_t            data_b_out;
    logic             stall_out;
    logic [NREG-1:0]  busy_out;

    modport master (
        output flush_in, issue_in, issue_write_in, issue_writenum_in,
        output use_a_in, use_b_in, readnum_a_in, readnum_b_in,
        output write_in, writenum_in, writeback_data_in,
        input  data_a_out, data_b_out, stall_out, busy_out
    );

    modport slave (
        input  flush_in, issue_in, issue_write_in, issue_writenum_in,
        input  use_a_in, use_b_in, readnum_a_in, readnum_b_in,
        input  write_in, writenum_in, writeback_data_in,
        output data_a_out, data_b_out, stall_out, busy_out
    );

endinterface

// File: rtl/scoreboard_cnt.sv
// Per-register outstanding-write counter: counts issued writes up, retiring
// writes down, saturates at all-ones and never underflows. Flush clears it.
module scoreboard_cnt #(
    parameter int unsigned CNTW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            inc_i,
    input  logic            ret_i,
    output logic [CNTW-1:0] cnt_o,
    output logic            busy_o
);

    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic            dec;
    logic            sat;

    // Retires against an empty count are post-flush stragglers and are ignored.
    assign dec = ret_i & (cnt_q != '0);
    assign sat = &cnt_q;

    // Next count: flush wins, simultaneous inc/dec cancel.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (inc_i & ~dec & ~sat) begin
            cnt_d = cnt_q + CNTW'(1);
        end else if (dec & ~inc_i) begin
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    // Counter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with an in-flight write scoreboard for decode.
// Two combinational read ports, one writeback port, per-register pending counts
// and a stall output for RAW hazards and counter saturation.
// Optional macro REGFILE_BYPASS_EN: forward writeback data to the read ports in the
// retire cycle and treat the retiring write as no longer pending.
module regfile_scoreboard #(
    parameter int unsigned CNTW = cpu_pkg::CNTW
) (
    input logic                 clk,
    input logic                 rst,
    regfile_scoreboard_if.slave bus
);
    import cpu_pkg::*;

    localparam logic [CNTW-1:0] CntMax = {CNTW{1'b1}};

    word_t           rf_q [NREG];
    word_t           rf_d [NREG];
    logic [CNTW-1:0] cnt  [NREG];
    logic [NREG-1:0] inc;
    logic [NREG-1:0] ret;
    logic [NREG-1:0] busy;
    logic            pend_a;
    logic            pend_b;
    logic            full;
    logic            stall;
    word_t           data_a;
    word_t           data_b;

    // Register array next state: single writeback port.
    always_comb begin
        rf_d = rf_q;
        if (bus.write_in) begin
            rf_d[bus.writenum_in] = bus.writeback_data_in;
        end
    end

    // Register array storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        // Only an issue that actually proceeds (not stalled) claims a count.
        assign inc[r] = bus.issue_in & ~stall & bus.issue_write_in &
                        (bus.issue_writenum_in == regnum_t'(r));
        assign ret[r] = bus.write_in & (bus.writenum_in == regnum_t'(r));

        scoreboard_cnt #(
            .CNTW (CNTW)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .flush_i (bus.flush_in),
            .inc_i   (inc[r]),
            .ret_i   (ret[r]),
            .cnt_o   (cnt[r]),
            .busy_o  (busy[r])
        );
    end

    // Hazard detection and stall; deliberately independent of flush_in.
    always_comb begin
        full = bus.issue_write_in & (cnt[bus.issue_writenum_in] == CntMax);
`ifdef REGFILE_BYPASS_EN
        // A single outstanding write that retires now is forwarded, so not pending.
        pend_a = (cnt[bus.readnum_a_in] != '0) &
                 ~((cnt[bus.readnum_a_in] == CNTW'(1)) & bus.write_in &
                   (bus.writenum_in == bus.readnum_a_in));
        pend_b = (cnt[bus.readnum_b_in] != '0) &
                 ~((cnt[bus.readnum_b_in] == CNTW'(1)) & bus.write_in &
                   (bus.writenum_in == bus.readnum_b_in));
`else
        // Without forwarding the write must land before the read sees it.
        pend_a = (cnt[bus.readnum_a_in] != '0) |
                 (bus.write_in & (bus.writenum_in == bus.readnum_a_in));
        pend_b = (cnt[bus.readnum_b_in] != '0) |
                 (bus.write_in & (bus.writenum_in == bus.readnum_b_in));
`endif
        stall = bus.issue_in & ((bus.use_a_in & pend_a) | (bus.use_b_in & pend_b) | full);
    end

    // Read port muxes.
    always_comb begin
        data_a = rf_q[bus.readnum_a_in];
        data_b = rf_q[bus.readnum_b_in];
`ifdef REGFILE_BYPASS_EN
        if (bus.write_in && (bus.writenum_in == bus.readnum_a_in)) begin
            data_a = bus.writeback_data_in;
        end
        if (bus.write_in && (bus.writenum_in == bus.readnum_b_in)) begin
            data_b = bus.writeback_data_in;
        end
`endif
    end

    assign bus.data_a_out = data_a;
    assign bus.data_b_out = data_b;
    assign bus.stall_out  = stall;
    assign bus.busy_out   = busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed testbench for regfile_scoreboard with hand-computed expectations.
// Expectations that depend on REGFILE_BYPASS_EN follow the same macro.
module tb_regfile_scoreboard;

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    regfile_scoreboard_if bus ();

    regfile_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.flush_in          = 1'b0;
        bus.issue_in          = 1'b0;
        bus.issue_write_in    = 1'b0;
        bus.issue_writenum_in = '0;
        bus.use_a_in          = 1'b0;
        bus.use_b_in          = 1'b0;
        bus.readnum_a_in      = '0;
        bus.readnum_b_in      = '0;
        bus.write_in          = 1'b0;
        bus.writenum_in       = '0;
        bus.writeback_data_in = '0;
    endtask

    // Advance past the next rising edge; inputs are then driven and checked off-edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input logic [2:0] rd);
        idle();
        bus.issue_in          = 1'b1;
        bus.issue_write_in    = 1'b1;
        bus.issue_writenum_in = rd;
    endtask

    task automatic retire(input logic [2:0] rd, input logic [15:0] d);
        idle();
        bus.write_in          = 1'b1;
        bus.writenum_in       = rd;
        bus.writeback_data_in = d;
    endtask

    initial begin
        idle();
        // Asynchronous reset asserted mid-cycle, checked before any clock edge.
        #7 rst = 1'b1;
        #1;
        check_eq("rst_busy", 32'(bus.busy_out), 32'h00);
        check_eq("rst_stall", 32'(bus.stall_out), 32'h0);
        for (int i = 0; i < 8; i++) begin
            bus.readnum_a_in = 3'(i);
            bus.readnum_b_in = 3'(7 - i);
            #1;
            check_eq($sformatf("rst_rd_a%0d", i), 32'(bus.data_a_out), 32'h0);
            check_eq($sformatf("rst_rd_b%0d", i), 32'(bus.data_b_out), 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
        tick();

        // Write R5 while a reader of R5 issues in the same cycle.
        retire(3'd5, 16'hBEEF);
        bus.issue_in     = 1'b1;
        bus.use_a_in     = 1'b1;
        bus.readnum_a_in = 3'd5;
        #1;
        check_eq("wr_same_data", 32'(bus.data_a_out), Bypass ? 32'hBEEF : 32'h0);
        check_eq("wr_same_stall", 32'(bus.stall_out), Bypass ? 32'h0 : 32'h1);
        tick();
        idle();
        bus.readnum_a_in = 3'd5;
        #1;
        check_eq("wr_next_data", 32'(bus.data_a_out), 32'hBEEF);
        check_eq("wr_next_busy", 32'(bus.busy_out), 32'h00);

        // RAW hazard on R3 via port B.
        issue_wr(3'd3);
        #1;
        check_eq("raw_issue_stall", 32'(bus.stall_out), 32'h0);
        tick();
        check_eq("raw_busy", 32'(bus.busy_out), 32'h08);
        idle();
        bus.issue_in     = 1'b1;
        bus.use_b_in     = 1'b1;
        bus.readnum_b_in = 3'd3;
        #1;
        check_eq("raw_stall_wait", 32'(bus.stall_out), 32'h1);
        tick();
        check_eq("raw_stall_hold", 32'(bus.stall_out), 32'h1);
        bus.write_in          = 1'b1;
        bus.writenum_in       = 3'd3;
        bus.writeback_data_in = 16'h1234;
        #1;
        check_eq("raw_stall_retire", 32'(bus.stall_out), Bypass ? 32'h0 : 32'h1);
        check_eq("raw_data_retire", 32'(bus.data_b_out), Bypass ? 32'h1234 : 32'h0);
        tick();
        bus.write_in = 1'b0;
        #1;
        check_eq("raw_busy_after", 32'(bus.busy_out), 32'h00);
        check_eq("raw_stall_after", 32'(bus.stall_out), 32'h0);
        check_eq("raw_data_after", 32'(bus.data_b_out), 32'h1234);

        // Simultaneous inc/dec on R2 keeps the count at one.
        issue_wr(3'd2);
        tick();
        issue_wr(3'd2);
        bus.write_in          = 1'b1;
        bus.writenum_in       = 3'd2;
        bus.writeback_data_in = 16'h2222;
        #1;
        check_eq("incdec_stall", 32'(bus.stall_out), 32'h0);
        tick();
        check_eq("incdec_busy", 32'(bus.busy_out), 32'h04);
        retire(3'd2, 16'h2223);
        tick();
        check_eq("incdec_drain", 32'(bus.busy_out), 32'h00);

        // Saturation on R6: three in flight, fourth stalls, three retires drain.
        for (int i = 0; i < 3; i++) begin
            issue_wr(3'd6);
            #1;
            check_eq($sformatf("sat_issue%0d", i), 32'(bus.stall_out), 32'h0);
            tick();
        end
        check_eq("sat_busy", 32'(bus.busy_out), 32'h40);
        issue_wr(3'd6);
        #1;
        check_eq("sat_full_stall", 32'(bus.stall_out), 32'h1);
        tick();
        for (int i = 0; i < 3; i++) begin
            retire(3'd6, 16'(16'h6000 + i));
            tick();
            check_eq($sformatf("sat_drain%0d", i), 32'(bus.busy_out), (i == 2) ? 32'h00 : 32'h40);
        end

        // Flush with counts on R1 (2) and R4 (1), plus a concurrent R4 writeback.
        issue_wr(3'd1);
        tick();
        issue_wr(3'd1);
        tick();
        issue_wr(3'd4);
        tick();
        check_eq("flush_pre_busy", 32'(bus.busy_out), 32'h12);
        issue_wr(3'd1);
        bus.flush_in          = 1'b1;
        bus.write_in          = 1'b1;
        bus.writenum_in       = 3'd4;
        bus.writeback_data_in = 16'h0042;
        #1;
        check_eq("flush_stall", 32'(bus.stall_out), 32'h0);
        tick();
        idle();
        bus.readnum_a_in = 3'd4;
        #1;
        check_eq("flush_busy", 32'(bus.busy_out), 32'h00);
        check_eq("flush_r4", 32'(bus.data_a_out), 32'h0042);
        retire(3'd1, 16'h1111);
        tick();
        idle();
        bus.readnum_a_in = 3'd1;
        #1;
        check_eq("straggler_busy", 32'(bus.busy_out), 32'h00);
        check_eq("straggler_data", 32'(bus.data_a_out), 32'h1111);

        // Reset in the middle of operation clears pending writes and data at once.
        issue_wr(3'd0);
        tick();
        check_eq("midrst_pre_busy", 32'(bus.busy_out), 32'h01);
        idle();
        bus.readnum_a_in = 3'd5;
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_busy", 32'(bus.busy_out), 32'h00);
        check_eq("midrst_r5", 32'(bus.data_a_out), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
